vid_pattern_overlay: RTL and testbench

VID_PATTERN_OVERLAY -- requirements
Module: vid_pattern_overlay

---
 rtl/vid_pkg.sv | 69 ++++++
 rtl/vid_timing_counter.sv | 104 ++++++++++
 rtl/vid_pattern_overlay.sv | 168 ++++++++++++++++
 tb/tb_vid_pattern_overlay.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video types, constants and small helpers for the pattern overlay block.
package vid_pkg;

    // Effective processing modes, selected once per frame.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CROSS = 2'd2,
        MODE_GRAY  = 2'd3
    } vid_mode_e;

    // Field order matches the pin packing: R in [23:16], B in [15:8], G in [7:0].
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] g;
    } vid_pixel_t;

    localparam int              CNT_W   = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = 12'hFFF;

    // Luma weights; they sum to 256 so full-scale white maps to 0xFF.
    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    localparam vid_pixel_t PIX_WHITE = 24'hFFFFFF;
    localparam vid_pixel_t PIX_RED   = 24'hFF0000;
    localparam vid_pixel_t PIX_BLACK = 24'h000000;

    // Bar colours, index 0 at the left edge of the line (R,B,G packing).
    localparam logic [3:0] BAR_COUNT = 4'd8;
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000,   // 7 black
        24'h00FF00,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFFFF00,   // 4 magenta
        24'h0000FF,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFF00FF,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

    // Counter increment that sticks at the top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + 12'd1;
        end
    endfunction

    // Colour for a bar index; anything past the last bar is black.
    function automatic vid_pixel_t bar_colour(input logic [3:0] idx);
        if (idx < BAR_COUNT) begin
            return vid_pixel_t'(BAR_TABLE[idx[2:0]]);
        end else begin
            return PIX_BLACK;
        end
    endfunction

    // Integer luma in 16-bit unsigned arithmetic, keeping the upper byte.
    function automatic logic [7:0] luma(input vid_pixel_t p);
        logic [15:0] acc;
        acc = LUMA_R * {8'd0, p.r} + LUMA_G * {8'd0, p.g} + LUMA_B * {8'd0, p.b};
        return 8'(acc >> 8);
    endfunction

endpackage

// File: rtl/vid_timing_counter.sv
// Input timing analysis: sync/active edge detection, pixel and line counters,
// and the per-frame width/height measurement with the frame_ok verdict.
module vid_timing_counter
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             vsync_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             vs_rise_o,
    output logic [CNT_W-1:0] meas_width_o,
    output logic [CNT_W-1:0] meas_height_o,
    output logic             frame_ok_o
);

    localparam logic [CNT_W-1:0] H_EXP = 12'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = 12'(V_ACTIVE);

    logic             active_q;
    logic             vsync_q;
    logic             seen_vs_q, seen_vs_d;
    logic             frame_ok_q, frame_ok_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] mw_q, mw_d;
    logic [CNT_W-1:0] mh_q, mh_d;
    logic             av_fall_s;
    logic             vs_rise_s;
    logic [CNT_W-1:0] y_line_s;
    logic [CNT_W-1:0] w_line_s;

    // Edge detection against last cycle's levels (both 0 straight after reset).
    always_comb begin
        av_fall_s = active_q & ~active_i;
        vs_rise_s = vsync_i & ~vsync_q;
    end

    // Counter and measurement next-state; a line ending in the vsync cycle is counted first.
    always_comb begin
        if (active_i) begin
            x_d = sat_inc(x_q);
        end else begin
            x_d = 12'd0;
        end

        if (av_fall_s) begin
            y_line_s = sat_inc(y_q);
            w_line_s = x_q;
        end else begin
            y_line_s = y_q;
            w_line_s = mw_q;
        end

        mw_d      = w_line_s;
        seen_vs_d = seen_vs_q | vs_rise_s;

        // frame_ok needs a previous vsync, so a frame cut short by reset never qualifies.
        if (vs_rise_s) begin
            y_d        = 12'd0;
            mh_d       = y_line_s;
            frame_ok_d = seen_vs_q && (w_line_s == H_EXP) && (y_line_s == V_EXP);
        end else begin
            y_d        = y_line_s;
            mh_d       = mh_q;
            frame_ok_d = frame_ok_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= 1'b0;
            vsync_q    <= 1'b0;
            seen_vs_q  <= 1'b0;
            frame_ok_q <= 1'b0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            mw_q       <= 12'd0;
            mh_q       <= 12'd0;
        end else begin
            active_q   <= active_i;
            vsync_q    <= vsync_i;
            seen_vs_q  <= seen_vs_d;
            frame_ok_q <= frame_ok_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mw_q       <= mw_d;
            mh_q       <= mh_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign vs_rise_o     = vs_rise_s;
    assign meas_width_o  = mw_q;
    assign meas_height_o = mh_q;
    assign frame_ok_o    = frame_ok_q;

endmodule

// File: rtl/vid_pattern_overlay.sv
// Video pattern/overlay stage: per-frame mode selection, pixel processing and a
// fixed two-cycle output pipeline, with timing measurement from the sub-module.
module vid_pattern_overlay
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        PixelClk,
    input  logic        aRst,
    input  logic [1:0]  mode,
    input  logic [23:0] in_data,
    input  logic        in_active_video,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [23:0] out_data,
    output logic        out_active_video,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic        frame_ok
);

    localparam logic [CNT_W-1:0] H_MID    = 12'(H_ACTIVE / 2);
    localparam logic [CNT_W-1:0] V_MID    = 12'(V_ACTIVE / 2);
    localparam logic [CNT_W-1:0] H_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    logic             vs_rise_s;

    vid_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]       bar_idx_q, bar_idx_d;

    vid_pixel_t       pix_in_s;
    vid_pixel_t       pix_s;
    logic [7:0]       luma_s;

    logic [23:0]      s1_data_q, s1_data_d;
    logic             s1_av_q, s1_hs_q, s1_vs_q;
    logic [23:0]      o_data_q;
    logic             o_av_q, o_hs_q, o_vs_q;

    vid_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk_i         (PixelClk),
        .rst_i         (aRst),
        .active_i      (in_active_video),
        .vsync_i       (in_vsync),
        .x_o           (x_s),
        .y_o           (y_s),
        .vs_rise_o     (vs_rise_s),
        .meas_width_o  (meas_width),
        .meas_height_o (meas_height),
        .frame_ok_o    (frame_ok)
    );

    // Mode is only taken on a vsync rise so a frame is never split between modes.
    always_comb begin
        if (vs_rise_s) begin
            mode_d = vid_mode_e'(mode);
        end else begin
            mode_d = mode_q;
        end
    end

    // Bar position by counting bar-width runs along the line, parking past the last bar.
    always_comb begin
        if (!in_active_video) begin
            bar_cnt_d = 12'd0;
            bar_idx_d = 4'd0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = 12'd0;
            if (bar_idx_q == BAR_COUNT) begin
                bar_idx_d = bar_idx_q;
            end else begin
                bar_idx_d = bar_idx_q + 4'd1;
            end
        end else begin
            bar_cnt_d = bar_cnt_q + 12'd1;
            bar_idx_d = bar_idx_q;
        end
    end

    // Pixel processing for the current input pixel; blanking always goes out black.
    always_comb begin
        pix_in_s = vid_pixel_t'(in_data);
        luma_s   = luma(pix_in_s);
        case (mode_q)
            MODE_PASS: begin
                pix_s = pix_in_s;
            end
            MODE_BARS: begin
                pix_s = bar_colour(bar_idx_q);
            end
            MODE_CROSS: begin
                if ((x_s == H_MID) || (y_s == V_MID)) begin
                    pix_s = PIX_WHITE;
                end else if ((x_s == 12'd0) || (x_s == H_LAST) ||
                             (y_s == 12'd0) || (y_s == V_LAST)) begin
                    pix_s = PIX_RED;
                end else begin
                    pix_s = pix_in_s;
                end
            end
            MODE_GRAY: begin
                pix_s = vid_pixel_t'({luma_s, luma_s, luma_s});
            end
            default: begin
                pix_s = pix_in_s;
            end
        endcase

        if (in_active_video) begin
            s1_data_d = pix_s;
        end else begin
            s1_data_d = PIX_BLACK;
        end
    end

    // Mode and bar-counter registers.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            mode_q    <= MODE_PASS;
            bar_cnt_q <= 12'd0;
            bar_idx_q <= 4'd0;
        end else begin
            mode_q    <= mode_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Two-stage output pipeline keeping data and timing aligned.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            s1_data_q <= 24'h000000;
            s1_av_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            o_data_q  <= 24'h000000;
            o_av_q    <= 1'b0;
            o_hs_q    <= 1'b0;
            o_vs_q    <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_av_q   <= in_active_video;
            s1_hs_q   <= in_hsync;
            s1_vs_q   <= in_vsync;
            o_data_q  <= s1_data_q;
            o_av_q    <= s1_av_q;
            o_hs_q    <= s1_hs_q;
            o_vs_q    <= s1_vs_q;
        end
    end

    assign out_data         = o_data_q;
    assign out_active_video = o_av_q;
    assign out_hsync        = o_hs_q;
    assign out_vsync        = o_vs_q;

endmodule

// File: tb/tb_vid_pattern_overlay.sv
// Self-checking bench for vid_pattern_overlay on a reduced 64x6 raster.
module tb_vid_pattern_overlay;

    localparam int H   = 64;
    localparam int V   = 6;
    localparam int HBL = 6;
    localparam int BW  = H / 8;

    logic        PixelClk = 1'b0;
    logic        aRst;
    logic [1:0]  mode;
    logic [23:0] in_data;
    logic        in_active_video, in_hsync, in_vsync;
    logic [23:0] out_data;
    logic        out_active_video, out_hsync, out_vsync;
    logic [11:0] meas_width, meas_height;
    logic        frame_ok;

    always #5 PixelClk = ~PixelClk;

    vid_pattern_overlay #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .PixelClk         (PixelClk),
        .aRst             (aRst),
        .mode             (mode),
        .in_data          (in_data),
        .in_active_video  (in_active_video),
        .in_hsync         (in_hsync),
        .in_vsync         (in_vsync),
        .out_data         (out_data),
        .out_active_video (out_active_video),
        .out_hsync        (out_hsync),
        .out_vsync        (out_vsync),
        .meas_width       (meas_width),
        .meas_height      (meas_height),
        .frame_ok         (frame_ok)
    );

    typedef struct {
        logic        av;
        logic        hs;
        logic        vs;
        logic [23:0] data;
        int          px;
        int          py;
    } exp_t;

    typedef struct {
        logic [1:0]  m;
        logic [23:0] din;
        int          x;
        int          y;
        logic [23:0] exp_pix;
    } vec_t;

    int          total = 0;
    int          passed = 0;
    int          stream_err = 0;
    int          nv = 0;
    exp_t        h0, h1;
    logic        prev_vs_m;
    logic [1:0]  eff_m;
    logic [23:0] cap [V][H];
    logic [23:0] bars [8];
    vec_t        vecs [27];

    function automatic logic [23:0] model_pixel(input logic [1:0] m, input int px, input int py,
                                                input logic [23:0] d);
        int r, g, b, l;
        case (m)
            2'd1: begin
                if (px / BW < 8) return bars[px / BW];
                else return 24'h000000;
            end
            2'd2: begin
                if (px == H / 2 || py == V / 2) return 24'hFFFFFF;
                else if (px == 0 || px == H - 1 || py == 0 || py == V - 1) return 24'hFF0000;
                else return d;
            end
            2'd3: begin
                r = int'(d[23:16]);
                b = int'(d[15:8]);
                g = int'(d[7:0]);
                l = ((77 * r + 150 * g + 29 * b) >> 8) & 255;
                return {l[7:0], l[7:0], l[7:0]};
            end
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic addv(input logic [1:0] m, input logic [23:0] d, input int x, input int y,
                        input logic [23:0] e);
        vecs[nv] = '{m: m, din: d, x: x, y: y, exp_pix: e};
        nv++;
    endtask

    function automatic exp_t zero_exp();
        return '{av: 1'b0, hs: 1'b0, vs: 1'b0, data: 24'h0, px: 0, py: 0};
    endfunction

    // Called at posedge+1: check outputs against inputs from two cycles back, then drive.
    task automatic drive_cycle(input logic av, input logic hs, input logic vs,
                               input logic [23:0] d, input int px, input int py);
        exp_t n;
        if (out_active_video !== h1.av || out_hsync !== h1.hs ||
            out_vsync !== h1.vs || out_data !== h1.data) begin
            stream_err++;
            if (stream_err <= 5)
                $display("stream diff t=%0t got av%b hs%b vs%b %h want av%b hs%b vs%b %h",
                         $time, out_active_video, out_hsync, out_vsync, out_data,
                         h1.av, h1.hs, h1.vs, h1.data);
        end
        if (h1.av && h1.px < H && h1.py < V) cap[h1.py][h1.px] = out_data;
        n.av = av; n.hs = hs; n.vs = vs; n.px = px; n.py = py;
        n.data = av ? model_pixel(eff_m, px, py, d) : 24'h0;
        if (aRst) begin
            n = zero_exp();
            eff_m = 2'd0;
            prev_vs_m = 1'b0;
        end else begin
            if (vs && !prev_vs_m) eff_m = mode;
            prev_vs_m = vs;
        end
        h1 = h0;
        h0 = n;
        in_active_video = av;
        in_hsync = hs;
        in_vsync = vs;
        in_data = d;
        @(posedge PixelClk);
        #1;
    endtask

    task automatic do_vsync();
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b1, 24'($urandom), 0, 0);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    endtask

    task automatic run_frame(input int w, input int lines, input logic rnd, input logic [23:0] cd,
                             input int sw_line, input logic [1:0] sw_mode, input logic merge);
        do_vsync();
        for (int l = 0; l < lines; l++) begin
            if (l == sw_line) mode = sw_mode;
            for (int p = 0; p < w; p++)
                drive_cycle(1'b1, 1'b0, 1'b0, rnd ? 24'($urandom) : cd, p, l);
            if (!(merge && l == lines - 1))
                for (int b = 0; b < HBL; b++)
                    drive_cycle(1'b0, (b >= 1 && b < 3), 1'b0, 24'($urandom), 0, 0);
        end
        chk("stream", 32'(stream_err), 32'd0);
        stream_err = 0;
    endtask

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFF00FF; bars[2] = 24'h00FFFF; bars[3] = 24'h0000FF;
        bars[4] = 24'hFFFF00; bars[5] = 24'hFF0000; bars[6] = 24'h00FF00; bars[7] = 24'h000000;

        addv(2'd1, 24'h123456,  0, 0, 24'hFFFFFF); addv(2'd1, 24'h123456,  7, 2, 24'hFFFFFF);
        addv(2'd1, 24'h123456,  8, 2, 24'hFF00FF); addv(2'd1, 24'h123456, 15, 1, 24'hFF00FF);
        addv(2'd1, 24'h123456, 16, 0, 24'h00FFFF); addv(2'd1, 24'h123456, 24, 3, 24'h0000FF);
        addv(2'd1, 24'h123456, 32, 4, 24'hFFFF00); addv(2'd1, 24'h123456, 40, 5, 24'hFF0000);
        addv(2'd1, 24'h123456, 48, 0, 24'h00FF00); addv(2'd1, 24'h123456, 56, 1, 24'h000000);
        addv(2'd1, 24'h123456, 63, 5, 24'h000000);
        addv(2'd2, 24'h000000, 32, 1, 24'hFFFFFF); addv(2'd2, 24'h000000,  5, 3, 24'hFFFFFF);
        addv(2'd2, 24'h000000,  0, 1, 24'hFF0000); addv(2'd2, 24'h000000, 10, 1, 24'h000000);
        addv(2'd2, 24'h000000, 63, 2, 24'hFF0000); addv(2'd2, 24'h000000, 10, 0, 24'hFF0000);
        addv(2'd2, 24'h000000, 10, 5, 24'hFF0000); addv(2'd2, 24'h000000, 32, 0, 24'hFFFFFF);
        addv(2'd2, 24'h000000,  0, 3, 24'hFFFFFF);
        addv(2'd2, 24'h0A0B0C, 10, 1, 24'h0A0B0C); addv(2'd2, 24'h0A0B0C,  0, 4, 24'hFF0000);
        addv(2'd3, 24'hFF0000,  3, 3, 24'h4C4C4C); addv(2'd3, 24'hFFFFFF,  3, 3, 24'hFFFFFF);
        addv(2'd3, 24'h0000FF, 20, 2, 24'h959595); addv(2'd3, 24'h00FF00, 20, 2, 24'h1C1C1C);
        addv(2'd0, 24'h5A5A5A,  3, 3, 24'h5A5A5A);

        h0 = zero_exp();
        h1 = zero_exp();
        eff_m = 2'd0;
        prev_vs_m = 1'b0;
        aRst = 1'b1;
        mode = 2'd0;
        in_data = 24'hFFFFFF;
        in_active_video = 1'b1;
        in_hsync = 1'b1;
        in_vsync = 1'b1;

        // Reset held with live inputs: everything stays at zero.
        repeat (3) @(posedge PixelClk);
        #1;
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_av", 32'(out_active_video), 32'h0);
        chk("rst_meas_width", 32'(meas_width), 32'h0);
        chk("rst_meas_height", 32'(meas_height), 32'h0);
        chk("rst_frame_ok", 32'(frame_ok), 32'h0);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        aRst = 1'b0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

        // First frame after reset: passthrough, random data, then measurement.
        run_frame(H, V, 1'b1, 24'h0, -1, 2'd0, 1'b0);
        chk("first_frame_ok_low", 32'(frame_ok), 32'h0);
        do_vsync();
        chk("second_vs_frame_ok", 32'(frame_ok), 32'h1);
        chk("second_vs_width", 32'(meas_width), 32'd64);
        chk("second_vs_height", 32'(meas_height), 32'd6);

        // Directed pixel vectors, one frame per distinct mode/data pair.
        for (int i = 0; i < nv; i++) begin
            if (i == 0 || vecs[i].m != vecs[i-1].m || vecs[i].din != vecs[i-1].din) begin
                mode = vecs[i].m;
                run_frame(H, V, 1'b0, vecs[i].din, -1, 2'd0, 1'b0);
            end
            chk($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vecs[i].m, vecs[i].x, vecs[i].y),
                32'(cap[vecs[i].y][vecs[i].x]), 32'(vecs[i].exp_pix));
        end

        // Mode change mid-frame only takes effect from the next frame.
        mode = 2'd0;
        run_frame(H, V, 1'b0, 24'h112233, -1, 2'd0, 1'b0);
        run_frame(H, V, 1'b0, 24'h112233, 3, 2'd1, 1'b0);
        chk("switch_same_frame", 32'(cap[4][0]), 32'h112233);
        run_frame(H, V, 1'b0, 24'h112233, -1, 2'd0, 1'b0);
        chk("switch_next_frame_bar0", 32'(cap[4][0]), 32'hFFFFFF);
        chk("switch_next_frame_bar1", 32'(cap[4][9]), 32'hFF00FF);

        // Short lines and short frames are measured and rejected.
        mode = 2'd0;
        run_frame(H - 2, V, 1'b1, 24'h0, -1, 2'd0, 1'b0);
        do_vsync();
        chk("short_line_width", 32'(meas_width), 32'd62);
        chk("short_line_height", 32'(meas_height), 32'd6);
        chk("short_line_frame_ok", 32'(frame_ok), 32'h0);
        run_frame(H, V - 1, 1'b1, 24'h0, -1, 2'd0, 1'b0);
        do_vsync();
        chk("short_frame_height", 32'(meas_height), 32'd5);
        chk("short_frame_ok", 32'(frame_ok), 32'h0);

        // Last line ends on the same cycle vsync rises: that line must be counted.
        run_frame(H, V, 1'b1, 24'h0, -1, 2'd0, 1'b1);
        do_vsync();
        chk("merge_height", 32'(meas_height), 32'd6);
        chk("merge_width", 32'(meas_width), 32'd64);
        chk("merge_frame_ok", 32'(frame_ok), 32'h1);

        // Asynchronous reset in the middle of an active line.
        do_vsync();
        for (int p = 0; p < 10; p++) drive_cycle(1'b1, 1'b0, 1'b0, 24'hABCDEF, p, 0);
        chk("pre_rst_out_data", 32'(out_data), 32'hABCDEF);
        #2;
        aRst = 1'b1;
        #1;
        chk("midrst_out_data", 32'(out_data), 32'h0);
        chk("midrst_out_av", 32'(out_active_video), 32'h0);
        chk("midrst_frame_ok", 32'(frame_ok), 32'h0);
        chk("midrst_meas_width", 32'(meas_width), 32'h0);
        chk("midrst_meas_height", 32'(meas_height), 32'h0);
        h0 = zero_exp();
        h1 = zero_exp();
        eff_m = 2'd0;
        prev_vs_m = 1'b0;
        @(posedge PixelClk);
        #1;
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        aRst = 1'b0;
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        run_frame(H, V, 1'b1, 24'h0, -1, 2'd0, 1'b0);
        chk("post_rst_first_ok", 32'(frame_ok), 32'h0);
        run_frame(H, V, 1'b1, 24'h0, -1, 2'd0, 1'b0);
        do_vsync();
        chk("post_rst_frame_ok", 32'(frame_ok), 32'h1);
        chk("post_rst_width", 32'(meas_width), 32'd64);
        chk("post_rst_height", 32'(meas_height), 32'd6);

        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        chk("tail_stream", 32'(stream_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
